// File: rtl/pwm_axil_slave.sv
// AXI4-Lite slave with a four-register bank (CTRL, PERIOD, DUTY, PRESCALE) that drives a
// single-channel PWM generator. Period parameters are shadowed so that a period, once it
// has started, always runs to completion with the values it started with.
module pwm_axil_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_PWM_WIDTH        = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pwm_out,
  output logic                            pwm_wrap
);

  typedef enum logic {StIdle, StRun} pwm_state_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
  logic                          awready_q, bvalid_q, arready_q, rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                    wr_idx, rd_idx;
  logic                          wr_accept, wr_fire, rd_accept, rd_fire;

  pwm_state_e             state_q;
  logic [C_PWM_WIDTH-1:0] presc_q, cnt_q, cnt_inc;
  logic [C_PWM_WIDTH-1:0] period_act_q, duty_act_q, presc_act_q;
  logic                   pwm_out_q, pwm_wrap_q;
  logic                   enable;

  // Protection bits and byte offsets within a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_idx    = S_AXI_AWADDR[3:2];
  assign rd_idx    = S_AXI_ARADDR[3:2];
  // Ready is raised only once both AW and W are present, so neither is ever taken alone.
  assign wr_accept = S_AXI_AWVALID && S_AXI_WVALID && !awready_q && !bvalid_q;
  assign wr_fire   = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_accept = S_AXI_ARVALID && !arready_q && !rvalid_q;
  assign rd_fire   = arready_q && S_AXI_ARVALID;
  assign enable    = regs_q[0][0];
  assign cnt_inc   = cnt_q + 1'b1;

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign pwm_out       = pwm_out_q;
  assign pwm_wrap      = pwm_wrap_q;

  // Write channel: one-cycle AW/W ready pulse, then B held until BREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      awready_q <= wr_accept;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Register bank with per-byte write enables.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_fire) begin
      for (int b = 0; b < C_S_AXI_DATA_WIDTH / 8; b++) begin
        if (S_AXI_WSTRB[b]) begin
          regs_q[wr_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  // Read channel: data sampled from the bank as it stands before any same-edge write.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= rd_accept;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= regs_q[rd_idx];
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // PWM engine: prescaler, period counter, shadow reload and registered outputs.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      cnt_q        <= '0;
      period_act_q <= '0;
      duty_act_q   <= '0;
      presc_act_q  <= '0;
      pwm_out_q    <= 1'b0;
      pwm_wrap_q   <= 1'b0;
    end else begin
      pwm_wrap_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          presc_q   <= '0;
          cnt_q     <= '0;
          pwm_out_q <= 1'b0;
          if (enable) begin
            state_q      <= StRun;
            period_act_q <= regs_q[1][C_PWM_WIDTH-1:0];
            duty_act_q   <= regs_q[2][C_PWM_WIDTH-1:0];
            presc_act_q  <= regs_q[3][C_PWM_WIDTH-1:0];
            pwm_out_q    <= (regs_q[2][C_PWM_WIDTH-1:0] != '0);
          end
        end
        StRun: begin
          if (!enable) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            cnt_q     <= '0;
            pwm_out_q <= 1'b0;
          end else if (presc_q == presc_act_q) begin
            presc_q <= '0;
            if (cnt_q == period_act_q) begin
              // Period boundary: new shadow values take effect from cnt=0.
              cnt_q        <= '0;
              pwm_wrap_q   <= 1'b1;
              period_act_q <= regs_q[1][C_PWM_WIDTH-1:0];
              duty_act_q   <= regs_q[2][C_PWM_WIDTH-1:0];
              presc_act_q  <= regs_q[3][C_PWM_WIDTH-1:0];
              pwm_out_q    <= (regs_q[2][C_PWM_WIDTH-1:0] != '0);
            end else begin
              cnt_q     <= cnt_inc;
              pwm_out_q <= (cnt_inc < duty_act_q);
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_axil_slave.sv
// Self-checking bench for pwm_axil_slave: AXI-Lite register access and PWM waveform
// checked against a register-array model and an arithmetic waveform model.
module tb_pwm_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, pwm_out, pwm_wrap;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_regs [4];

  always #5 clk = ~clk;

  pwm_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .C_PWM_WIDTH(16)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .pwm_out(pwm_out),
    .pwm_wrap(pwm_wrap)
  );

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int n = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (awready !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    checks++;
    if (awready !== 1'b1 || wready !== 1'b1) begin
      errors++;
      $display("FAIL wr_handshake addr=%h: awready=%b wready=%b, required 1/1", addr, awready,
               wready);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    step(1);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) model_regs[addr[3:2]][8*b +: 8] = data[8*b +: 8];
    end
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL wr_bresp addr=%h: bvalid=%b bresp=%b, required 1/00", addr, bvalid, bresp);
    end
    step(1);
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_bdrop addr=%h: bvalid=%b, required 0", addr, bvalid);
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n = 0;
    araddr = addr; arvalid = 1'b1;
    data = 'x; resp = 'x;
    while (arready !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL rd_handshake addr=%h: arready=%b, required 1", addr, arready);
      arvalid = 1'b0;
      return;
    end
    step(1);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rd_rvalid addr=%h: rvalid=%b, required 1", addr, rvalid);
    end
    data = rdata; resp = rresp;
    rready = 1'b1;
    step(1);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    step(2);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, pwm_out, pwm_wrap} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: aw/w/b/ar/r/pwm/wrap=%b, required 0000000",
               {awready, wready, bvalid, arready, rvalid, pwm_out, pwm_wrap});
    end
    checks++;
    if (rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_data: rdata=%h, required 0", rdata);
    end
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_basic_rw();
    logic [31:0] d;
    logic [1:0]  r;
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r);
      checks++;
      if (d !== 32'(i + 1) || r !== 2'b00) begin
        errors++;
        $display("FAIL basic_rd[%0d]: rdata=%h rresp=%b, required %h/00", i, d, r, i + 1);
      end
    end
    axi_write(4'h0, 32'h0, 4'hF);
  endtask

  task automatic test_wstrb();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(4'h4, 32'h11223344, 4'hF);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0010);
    axi_read(4'h4, d, r);
    checks++;
    if (d !== 32'h1122CC44) begin
      errors++;
      $display("FAIL wstrb_merge: rdata=%h, required 1122cc44", d);
    end
    axi_write(4'h8, 32'hDEADBEEF, 4'h0);
    axi_read(4'h8, d, r);
    checks++;
    if (d !== model_regs[2]) begin
      errors++;
      $display("FAIL wstrb_zero: rdata=%h, required %h", d, model_regs[2]);
    end
  endtask

  task automatic test_random_rw();
    logic [31:0] d;
    logic [1:0]  r;
    logic [1:0]  a;
    for (int i = 0; i < 24; i++) begin
      a = 2'($urandom_range(3, 0));
      if ($urandom_range(1, 0) == 1) begin
        // Keep ENABLE clear so the PWM stays idle during register traffic.
        d = $urandom;
        if (a == 2'd0) d[0] = 1'b0;
        axi_write({a, 2'b00}, d, 4'($urandom_range(15, 0)));
      end else begin
        axi_read({a, 2'b00}, d, r);
        checks++;
        if (d !== model_regs[a]) begin
          errors++;
          $display("FAIL rand_rd[%0d] reg%0d: rdata=%h, required %h", i, a, d, model_regs[a]);
        end
      end
      step($urandom_range(2, 0));
    end
  endtask

  task automatic test_delayed_write();
    logic [31:0] d;
    logic [1:0]  r;
    int n = 0;
    awaddr = 4'h8; wdata = 32'h00000055; wstrb = 4'hF;
    awvalid = 1'b1; bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if (awready !== 1'b0 || wready !== 1'b0) begin
        errors++;
        $display("FAIL dly_no_accept[%0d]: awready=%b wready=%b, required 0/0", i, awready,
                 wready);
      end
    end
    wvalid = 1'b1;
    while (awready !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    step(1);
    awvalid = 1'b0; wvalid = 1'b0;
    model_regs[2] = 32'h00000055;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        errors++;
        $display("FAIL dly_bhold[%0d]: bvalid=%b awready=%b, required 1/0", i, bvalid, awready);
      end
      step(1);
    end
    bready = 1'b1;
    step(1);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL dly_bdrop: bvalid=%b, required 0", bvalid);
    end
    axi_read(4'h8, d, r);
    checks++;
    if (d !== 32'h55) begin
      errors++;
      $display("FAIL dly_rd: rdata=%h, required 00000055", d);
    end
  endtask

  // Waveform model: sample k counts clocks from the enabling load. Period length is
  // (p+1)*(s+1); within a period the tick index is pos/(s+1) and the output is high while
  // that index is below the duty in force for the period.
  task automatic run_pwm(input int p, input int d, input int s, input int d_mid,
                         input int ncyc, input string name);
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'(p), 4'hF);
    axi_write(4'h8, 32'(d), 4'hF);
    axi_write(4'hC, 32'(s), 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    fork
      begin
        for (int k = 0; k < ncyc; k++) begin
          int   len      = (p + 1) * (s + 1);
          int   per      = k / len;
          int   pos      = k % len;
          int   tick     = pos / (s + 1);
          int   dd       = (d_mid >= 0 && per > 0) ? d_mid : d;
          logic exp_out  = (tick < dd);
          logic exp_wrap = (k > 0 && pos == 0);
          checks++;
          if (pwm_out !== exp_out) begin
            errors++;
            $display("FAIL %s pwm_out k=%0d: got %b, required %b", name, k, pwm_out, exp_out);
          end
          checks++;
          if (pwm_wrap !== exp_wrap) begin
            errors++;
            $display("FAIL %s pwm_wrap k=%0d: got %b, required %b", name, k, pwm_wrap,
                     exp_wrap);
          end
          step(1);
        end
      end
      begin
        if (d_mid >= 0) begin
          step(2);
          axi_write(4'h8, 32'(d_mid), 4'hF);
        end
      end
    join
  endtask

  task automatic test_pwm();
    int p, d, s;
    run_pwm(9, 3, 0, -1, 32, "pwm_basic");
    run_pwm(9, 3, 0, 7, 32, "pwm_mid_duty");
    run_pwm(9, 0, 0, -1, 25, "pwm_duty0");
    run_pwm(9, 12, 0, -1, 25, "pwm_duty_gt");
    run_pwm(9, 3, 1, -1, 45, "pwm_presc1");
    for (int i = 0; i < 3; i++) begin
      p = int'($urandom_range(6, 1));
      d = int'($urandom_range(8, 0));
      s = int'($urandom_range(2, 0));
      run_pwm(p, d, s, -1, 2 * (p + 1) * (s + 1) + 3, "pwm_rand");
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r;
    int n = 0;
    run_pwm(9, 12, 0, -1, 4, "pwm_pre_reset");
    // Leave a read response outstanding, then reset underneath it.
    araddr = 4'h4; arvalid = 1'b1;
    while (arready !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    step(1);
    arvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 1'b0 || pwm_wrap !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pwm: pwm_out=%b pwm_wrap=%b, required 0/0", pwm_out, pwm_wrap);
    end
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_r: rvalid=%b rdata=%h, required 0/0", rvalid, rdata);
    end
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r);
      checks++;
      if (d !== model_regs[i]) begin
        errors++;
        $display("FAIL rst_mid_reg%0d: rdata=%h, required %h", i, d, model_regs[i]);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_rw();
    test_wstrb();
    test_random_rw();
    test_delayed_write();
    test_pwm();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
